// File: rtl/multiplexador_pkg.sv
// Shared definitions for the registered, handshaked N-channel multiplexer.
// Holds the output-register state encoding and the default sizes.
package multiplexador_pkg;

  typedef enum logic {
    VAZIO = 1'b0,
    CHEIO = 1'b1
  } estado_t;

  localparam int WIDTH_PADRAO  = 32;
  localparam int CANAIS_PADRAO = 4;

endpackage

// File: rtl/multiplexador_pipe_arbitro_rr.sv
// Round-robin grant search: the first valid channel at or above ptr, wrapping to 0.
// Purely combinational; ptr is owned by the instantiating block.
module arbitro_rr #(
  parameter  int CANAIS = 4,
  localparam int SEL_W  = $clog2(CANAIS)
) (
  input  logic [CANAIS-1:0] in_valid,
  input  logic [SEL_W-1:0]  ptr,
  output logic [SEL_W-1:0]  grant,
  output logic              tem_grant
);

  // Two passes (upper segment, then the wrapped lower one) avoid modular index math,
  // so a non-power-of-two CANAIS never relies on SEL_W overflow.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; otherwise a latch is inferred.
    grant     = '0;
    tem_grant = 1'b0;
    for (int i = 0; i < CANAIS; i++) begin
      if (!tem_grant && i >= int'(ptr) && in_valid[i]) begin
        grant     = SEL_W'(i);
        tem_grant = 1'b1;
      end
    end
    for (int i = 0; i < CANAIS; i++) begin
      if (!tem_grant && i < int'(ptr) && in_valid[i]) begin
        grant     = SEL_W'(i);
        tem_grant = 1'b1;
      end
    end
  end

endmodule

// File: rtl/multiplexador_pipe.sv
// N-channel registered multiplexer with valid/ready on every input and the output.
// Define MULTIPLEXADOR_RR_EN to add the modo port and round-robin arbitration.
module multiplexador_pipe
  import multiplexador_pkg::*;
#(
  parameter  int WIDTH  = WIDTH_PADRAO,
  parameter  int CANAIS = CANAIS_PADRAO,
  localparam int SEL_W  = $clog2(CANAIS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [SEL_W-1:0]        sel,
`ifdef MULTIPLEXADOR_RR_EN
  input  logic                    modo,
`endif
  input  logic [CANAIS*WIDTH-1:0] in_data,
  input  logic [CANAIS-1:0]       in_valid,
  output logic [CANAIS-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_canal,
  output logic                    out_valid,
  input  logic                    out_ready
);

  estado_t          estado, estado_prox;
  logic [SEL_W-1:0] g;
  logic             g_ok;
  logic             pode_carregar;
  logic             transfer;
  logic [WIDTH-1:0] dado_sel;

`ifdef MULTIPLEXADOR_RR_EN
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] g_rr;
  logic             tem_grant;

  arbitro_rr #(.CANAIS(CANAIS)) u_arbitro (
    .in_valid  (in_valid),
    .ptr       (ptr),
    .grant     (g_rr),
    .tem_grant (tem_grant)
  );

  assign g    = modo ? g_rr : sel;
  assign g_ok = modo ? tem_grant : (int'(sel) < CANAIS);

  // The pointer advances on every transfer, fixed mode included, and survives modo switches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (transfer) begin
      ptr <= (g == SEL_W'(CANAIS - 1)) ? '0 : g + 1'b1;
    end
  end
`else
  assign g    = sel;
  assign g_ok = int'(sel) < CANAIS;
`endif

  assign pode_carregar = (estado == VAZIO) || out_ready;

  always_comb begin
    in_ready = '0;
    dado_sel = '0;
    for (int i = 0; i < CANAIS; i++) begin
      in_ready[i] = pode_carregar && g_ok && (g == SEL_W'(i));
      if (g == SEL_W'(i)) dado_sel = in_data[i*WIDTH +: WIDTH];
    end
  end

  assign transfer = |(in_valid & in_ready);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) estado <= VAZIO;
    else        estado <= estado_prox;
  end

  // A load always wins over a drain, so a simultaneous drain+load keeps the output full.
  always_comb begin
    estado_prox = estado;
    if (transfer)                           estado_prox = CHEIO;
    else if (estado == CHEIO && out_ready)  estado_prox = VAZIO;
  end

  always_comb begin
    out_valid = (estado == CHEIO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_canal <= '0;
    end else if (transfer) begin
      out_data  <= dado_sel;
      out_canal <= g;
    end
  end

endmodule

// File: tb/tb_multiplexador_pipe.sv
// Directed bench for multiplexador_pipe: fixed-select table plus corner sequences.
// Round-robin sequences are compiled only when MULTIPLEXADOR_RR_EN is defined.
module tb_multiplexador_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // CANAIS = 4
  logic [1:0]   sel4 = '0;
  logic [3:0]   vld4 = '0, rdy4;
  logic         ordy4 = 1'b0, ov4;
  logic [31:0]  dat4 [4];
  logic [127:0] in4;
  logic [31:0]  od4;
  logic [1:0]   oc4;
  assign in4 = {dat4[3], dat4[2], dat4[1], dat4[0]};

  // CANAIS = 3 (sel = 3 is out of range)
  logic [1:0]   sel3 = '0;
  logic [2:0]   vld3 = '0, rdy3;
  logic         ordy3 = 1'b0, ov3;
  logic [95:0]  in3;
  logic [31:0]  od3;
  logic [1:0]   oc3;
  assign in3 = {32'h0000_0302, 32'h0000_0301, 32'h0000_0300};

`ifdef MULTIPLEXADOR_RR_EN
  logic         modo4 = 1'b0;
  logic         modo3 = 1'b0;
  logic         modo5 = 1'b0;
  logic [2:0]   sel5 = '0;
  logic [4:0]   vld5 = '0, rdy5;
  logic         ordy5 = 1'b0, ov5;
  logic [159:0] in5;
  logic [31:0]  od5;
  logic [2:0]   oc5;
  assign in5 = {32'h0000_0504, 32'h0000_0503, 32'h0000_0502, 32'h0000_0501, 32'h0000_0500};

  multiplexador_pipe #(.WIDTH(32), .CANAIS(5)) d5 (
    .clk(clk), .rst_n(rst_n), .sel(sel5), .modo(modo5), .in_data(in5), .in_valid(vld5),
    .in_ready(rdy5), .out_data(od5), .out_canal(oc5), .out_valid(ov5), .out_ready(ordy5)
  );
`endif

  multiplexador_pipe #(.WIDTH(32), .CANAIS(4)) d4 (
    .clk(clk), .rst_n(rst_n), .sel(sel4),
`ifdef MULTIPLEXADOR_RR_EN
    .modo(modo4),
`endif
    .in_data(in4), .in_valid(vld4), .in_ready(rdy4), .out_data(od4), .out_canal(oc4),
    .out_valid(ov4), .out_ready(ordy4)
  );

  multiplexador_pipe #(.WIDTH(32), .CANAIS(3)) d3 (
    .clk(clk), .rst_n(rst_n), .sel(sel3),
`ifdef MULTIPLEXADOR_RR_EN
    .modo(modo3),
`endif
    .in_data(in3), .in_valid(vld3), .in_ready(rdy3), .out_data(od3), .out_canal(oc3),
    .out_valid(ov3), .out_ready(ordy3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0]  sel;
    logic [3:0]  vld;
    logic        ordy;
    logic [3:0]  exp_rdy;
    logic        exp_ov;
    logic [31:0] exp_d;
    logic [1:0]  exp_c;
  } vec_t;

  vec_t tab [7];

  initial begin
    for (int i = 0; i < 4; i++) dat4[i] = 32'h0000_00C0 + 32'(i);

    tab[0] = '{2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 32'h0000_00C2, 2'd2}; // empty: load ch2
    tab[1] = '{2'd1, 4'b1111, 1'b1, 4'b0010, 1'b1, 32'h0000_00C1, 2'd1}; // drain+load
    tab[2] = '{2'd3, 4'b0111, 1'b1, 4'b1000, 1'b0, 32'h0000_00C1, 2'd1}; // ch3 idle: drain
    tab[3] = '{2'd0, 4'b0000, 1'b0, 4'b0001, 1'b0, 32'h0000_00C1, 2'd1}; // empty, nothing valid
    tab[4] = '{2'd3, 4'b1000, 1'b0, 4'b1000, 1'b1, 32'h0000_00C3, 2'd3}; // empty loads despite !out_ready
    tab[5] = '{2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 32'h0000_00C3, 2'd3}; // full, blocked
    tab[6] = '{2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 32'h0000_00C0, 2'd0}; // full, drain+load

    // Reset state
    #1;
    check("rst out_valid", 32'(ov4), 32'd0);
    check("rst out_data", od4, 32'd0);
    check("rst out_canal", 32'(oc4), 32'd0);
    check("rst in_ready (empty, sel=0)", 32'(rdy4), 32'b0001);
    tick();
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Fixed-select vector table
    for (int i = 0; i < 7; i++) begin
      sel4 = tab[i].sel; vld4 = tab[i].vld; ordy4 = tab[i].ordy;
      #1;
      check($sformatf("vec%0d in_ready", i), 32'(rdy4), 32'(tab[i].exp_rdy));
      tick();
      check($sformatf("vec%0d out_valid", i), 32'(ov4), 32'(tab[i].exp_ov));
      check($sformatf("vec%0d out_data", i), od4, tab[i].exp_d);
      check($sformatf("vec%0d out_canal", i), 32'(oc4), 32'(tab[i].exp_c));
    end

    // Back-pressure: A1 held three cycles, sel moves, then drain+load with no bubble
    dat4[1] = 32'h0000_00A1; sel4 = 2'd1; vld4 = 4'b1111; ordy4 = 1'b1;
    tick();
    check("bp load data", od4, 32'h0000_00A1);
    ordy4 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("bp%0d in_ready", c), 32'(rdy4), 32'd0);
      tick();
      check($sformatf("bp%0d held data", c), od4, 32'h0000_00A1);
      check($sformatf("bp%0d held valid", c), 32'(ov4), 32'd1);
    end
    sel4 = 2'd0;
    #1;
    check("bp sel0 in_ready", 32'(rdy4), 32'd0);
    tick();
    check("bp sel0 held data", od4, 32'h0000_00A1);
    check("bp sel0 held canal", 32'(oc4), 32'd1);
    ordy4 = 1'b1;
    #1;
    check("bp release in_ready", 32'(rdy4), 32'b0001);
    tick();
    check("bp release data", od4, 32'h0000_00C0);
    check("bp release canal", 32'(oc4), 32'd0);
    check("bp release no bubble", 32'(ov4), 32'd1);
    vld4 = 4'b0000;

    // Out-of-range select with CANAIS = 3
    sel3 = 2'd1; vld3 = 3'b111; ordy3 = 1'b0;
    #1;
    check("oor load in_ready", 32'(rdy3), 32'b010);
    tick();
    check("oor load valid", 32'(ov3), 32'd1);
    check("oor load data", od3, 32'h0000_0301);
    sel3 = 2'd3;
    #1;
    check("oor sel3 blocked in_ready", 32'(rdy3), 32'd0);
    tick();
    check("oor sel3 held valid", 32'(ov3), 32'd1);
    ordy3 = 1'b1;
    #1;
    check("oor sel3 drain in_ready", 32'(rdy3), 32'd0);
    tick();
    check("oor drained valid", 32'(ov3), 32'd0);
    check("oor drained data kept", od3, 32'h0000_0301);
    check("oor drained canal kept", 32'(oc3), 32'd1);
    vld3 = 3'b000;

    // Asynchronous reset while a word is held
    dat4[2] = 32'h0000_DEAD; sel4 = 2'd2; vld4 = 4'b0100; ordy4 = 1'b0;
    tick();
    check("arst loaded", od4, 32'h0000_DEAD);
    vld4 = 4'b0000;
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst out_valid", 32'(ov4), 32'd0);
    check("arst out_data", od4, 32'd0);
    check("arst out_canal", 32'(oc4), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();

`ifdef MULTIPLEXADOR_RR_EN
    // Round-robin, CANAIS = 3, all valid from ptr = 0
    modo3 = 1'b1; vld3 = 3'b111; ordy3 = 1'b1;
    #1;
    check("rr all in_ready", 32'(rdy3), 32'b001);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("rr all canal%0d", k), 32'(oc3), 32'(k % 3));
    end
    vld3 = 3'b000;
    #1;
    check("rr none in_ready", 32'(rdy3), 32'd0);
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    // Only ch1 and ch2 valid from ptr = 0
    vld3 = 3'b110;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("rr ch12 canal%0d", k), 32'(oc3), (k == 1) ? 32'd2 : 32'd1);
    end

    // Wrap with CANAIS = 5
    modo5 = 1'b1; ordy5 = 1'b1; vld5 = 5'b01000;
    tick();
    check("wrap ch3 to ptr4", 32'(oc5), 32'd3);
    vld5 = 5'b10000;
    #1;
    check("wrap ch4 in_ready", 32'(rdy5), 32'b10000);
    tick();
    check("wrap grant4 canal", 32'(oc5), 32'd4);
    check("wrap grant4 data", od5, 32'h0000_0504);
    vld5 = 5'b01000;
    tick();
    check("wrap ptr0 grant3", 32'(oc5), 32'd3);
    vld5 = 5'b11111;
    tick();
    check("wrap all from ptr4", 32'(oc5), 32'd4);
    tick();
    check("wrap all from ptr0", 32'(oc5), 32'd0);
    modo5 = 1'b0; sel5 = 3'd3;
    tick();
    check("switch fixed sel3", 32'(oc5), 32'd3);
    modo5 = 1'b1;
    tick();
    check("switch rr after fixed", 32'(oc5), 32'd4);
    vld5 = 5'b00000;
`endif

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
